// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: CPU port, debug/loader port and the shared memory port.
// master = arbiter side, slave = the core, debug agent and memory around it.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Read-return owner state of the arbiter, for observation only.
  logic [1:0]        owner_state;

  // Handshake: cpu_rd/cpu_wr and dbg_req are requests held by their source until
  // accepted; a CPU request is accepted in any cycle cpu_stall is low, a debug
  // request in the cycle dbg_gnt is high. Read data returns the following cycle.
  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner_state
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU and a debug/loader agent.
// Default: CPU priority with debug starvation counter; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 9,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  owner_t            owner;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_c;
  logic [DATA_W-1:0] dbg_rdata_c;
  logic              cpu_req;
  logic              dbg_win;
  logic              gnt_cpu;
  logic              gnt_dbg;

`ifdef DMEM_ARB_RR_EN
  // High when the CPU has priority on the next contention cycle.
  logic rr_cpu_pri;
`else
  localparam int CNT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBG_MAX_WAIT);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_comb begin
    cpu_req = bus.cpu_rd | bus.cpu_wr;
`ifdef DMEM_ARB_RR_EN
    dbg_win = bus.dbg_req & (~cpu_req | ~rr_cpu_pri);
`else
    dbg_win = bus.dbg_req & (~cpu_req | (wait_cnt == CNT_MAX));
`endif
    gnt_dbg = ~reset & dbg_win;
    gnt_cpu = ~reset & cpu_req & ~dbg_win;
  end

  always_comb begin
    bus.cpu_stall = ~reset & cpu_req & ~gnt_cpu;
    bus.dbg_gnt   = gnt_dbg;
    bus.mem_rd    = (gnt_cpu & bus.cpu_rd) | (gnt_dbg & ~bus.dbg_we);
    bus.mem_wr    = (gnt_cpu & bus.cpu_wr) | (gnt_dbg & bus.dbg_we);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_cpu) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (gnt_dbg) begin
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  // Read data is forwarded straight from memory in the return cycle and held
  // afterwards; reset masks the return so a read in flight never surfaces.
  always_comb begin
    cpu_rdata_c = cpu_rdata_q;
    dbg_rdata_c = dbg_rdata_q;
    if (reset) begin
      cpu_rdata_c = '0;
      dbg_rdata_c = '0;
    end else if (owner == OWN_CPU) begin
      cpu_rdata_c = bus.mem_rdata;
    end else if (owner == OWN_DBG) begin
      dbg_rdata_c = bus.mem_rdata;
    end
    bus.cpu_rdata   = cpu_rdata_c;
    bus.dbg_rdata   = dbg_rdata_c;
    bus.dbg_rvalid  = ~reset & (owner == OWN_DBG);
    bus.owner_state = owner;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= OWN_NONE;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_cpu_pri  <= 1'b1;
`else
      wait_cnt    <= '0;
`endif
    end else begin
      cpu_rdata_q <= cpu_rdata_c;
      dbg_rdata_q <= dbg_rdata_c;
      if (gnt_cpu && bus.cpu_rd)
        owner <= OWN_CPU;
      else if (gnt_dbg && !bus.dbg_we)
        owner <= OWN_DBG;
      else
        owner <= OWN_NONE;
`ifdef DMEM_ARB_RR_EN
      // Pointer moves only when both sides competed.
      if (cpu_req && bus.dbg_req)
        rr_cpu_pri <= gnt_dbg;
`else
      if (!bus.dbg_req || gnt_dbg)
        wait_cnt <= '0;
      else if (wait_cnt != CNT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: rule-level reference model checked every cycle,
// plus literal expectations for the key scenarios. Honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 9;
  localparam int DBG_MAX_WAIT = 4;
  localparam int DEPTH        = 1 << ADDR_W;

  logic clk;
  logic reset;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory environment ----------------
  logic [DATA_W-1:0] env_mem   [DEPTH];
  logic [DATA_W-1:0] model_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_wr) env_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= env_mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int                m_wait   = 0;
  bit                m_rr_cpu = 1'b1;
  int                m_owner  = 0;   // 0 none, 1 cpu read returning, 2 debug read returning
  logic [DATA_W-1:0] m_cpu_data = '0;
  logic [DATA_W-1:0] m_cpu_hold = '0;
  logic [DATA_W-1:0] m_dbg_hold = '0;

  always @(negedge clk) begin
    bit creq, gc, gd, e_rvalid;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_cpu_rdata, e_dbg_rdata;
    creq = bus.cpu_rd | bus.cpu_wr;
    gc = 1'b0;
    gd = 1'b0;
    if (!reset) begin
      if (creq && bus.dbg_req) begin
`ifdef DMEM_ARB_RR_EN
        gd = !m_rr_cpu;
`else
        gd = (m_wait == DBG_MAX_WAIT);
`endif
        gc = !gd;
      end else begin
        gc = creq;
        gd = bus.dbg_req;
      end
    end
    e_addr  = gc ? bus.cpu_addr  : gd ? bus.dbg_addr  : '0;
    e_wdata = gc ? bus.cpu_wdata : gd ? bus.dbg_wdata : '0;
    e_rvalid = !reset && (m_owner == 2);
    e_cpu_rdata = reset ? '0 : (m_owner == 1) ? m_cpu_data : m_cpu_hold;
    e_dbg_rdata = reset ? '0 : (e_rvalid && exp_q.size() > 0) ? exp_q[0] : m_dbg_hold;

    check("model_dbg_gnt",   bus.dbg_gnt,   gd);
    check("model_cpu_stall", bus.cpu_stall, !reset && creq && !gc);
    check("model_mem_rd",    bus.mem_rd,    (gc && bus.cpu_rd) || (gd && !bus.dbg_we));
    check("model_mem_wr",    bus.mem_wr,    (gc && bus.cpu_wr) || (gd && bus.dbg_we));
    check("model_mem_addr",  bus.mem_addr,  e_addr);
    check("model_mem_wdata", bus.mem_wdata, e_wdata);
    check("model_dbg_rvalid", bus.dbg_rvalid, e_rvalid);
    check("model_dbg_rdata", bus.dbg_rdata, e_dbg_rdata);
    check("model_cpu_rdata", bus.cpu_rdata, e_cpu_rdata);

    if (reset) begin
      m_wait = 0; m_rr_cpu = 1'b1; m_owner = 0;
      m_cpu_hold = '0; m_dbg_hold = '0;
      exp_q.delete();
    end else begin
      m_cpu_hold = e_cpu_rdata;
      if (e_rvalid && exp_q.size() > 0) begin
        m_dbg_hold = exp_q.pop_front();
      end
      if (!bus.dbg_req || gd) m_wait = 0;
      else if (m_wait < DBG_MAX_WAIT) m_wait++;
      if (creq && bus.dbg_req) m_rr_cpu = gd;
      m_owner = 0;
      if (gc && bus.cpu_rd) begin
        m_owner = 1;
        m_cpu_data = model_mem[bus.cpu_addr];
      end else if (gd && !bus.dbg_we) begin
        m_owner = 2;
        exp_q.push_back(model_mem[bus.dbg_addr]);
      end
      if (gc && bus.cpu_wr) model_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (gd && bus.dbg_we) model_mem[bus.dbg_addr] = bus.dbg_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic cpu_drive(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dbg_drive(input bit req, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  typedef struct {
    bit rd; bit wr; logic [ADDR_W-1:0] ca; logic [DATA_W-1:0] cd;
    bit dq; bit dw; logic [ADDR_W-1:0] da; logic [DATA_W-1:0] dd;
  } vec_t;

  vec_t mix[8];

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i]   = 32'h1000_0000 + i;
      model_mem[i] = 32'h1000_0000 + i;
    end
    env_mem[5]      = 32'hDEAD_BEEF; model_mem[5]      = 32'hDEAD_BEEF;
    env_mem[9'h010] = 32'hA5A5_0010; model_mem[9'h010] = 32'hA5A5_0010;
    bus.mem_rdata = '0;
    idle();
    reset = 1'b1;

    // Requests held during reset must not reach memory.
    cpu_drive(1, 0, 9'h005, '0);
    dbg_drive(1, 1, 9'h0AA, 32'h5555_5555);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_mem_rd",    bus.mem_rd,    1'b0);
    check("reset_mem_wr",    bus.mem_wr,    1'b0);
    check("reset_dbg_gnt",   bus.dbg_gnt,   1'b0);
    check("reset_cpu_stall", bus.cpu_stall, 1'b0);
    check("reset_cpu_rdata", bus.cpu_rdata, 32'h0);
    next_cycle();
    idle();
    reset = 1'b0;
    next_cycle();

    // CPU read only.
    cpu_drive(1, 0, 9'h005, '0);
    @(negedge clk);
    check("cpu_rd_mem_rd", bus.mem_rd,    1'b1);
    check("cpu_rd_stall",  bus.cpu_stall, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("cpu_rd_data", bus.cpu_rdata, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("cpu_rd_hold", bus.cpu_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Debug write, then debug read back.
    dbg_drive(1, 1, 9'h1FF, 32'h1234_5678);
    @(negedge clk);
    check("dbg_wr_gnt",    bus.dbg_gnt, 1'b1);
    check("dbg_wr_mem_wr", bus.mem_wr,  1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    check("dbg_wr_no_rvalid", bus.dbg_rvalid, 1'b0);
    next_cycle();
    dbg_drive(1, 0, 9'h1FF, '0);
    next_cycle();
    idle();
    @(negedge clk);
    check("dbg_rd_rvalid", bus.dbg_rvalid, 1'b1);
    check("dbg_rd_data",   bus.dbg_rdata,  32'h1234_5678);
    next_cycle();
    @(negedge clk);
    check("dbg_rd_pulse_end", bus.dbg_rvalid, 1'b0);
    check("dbg_rd_hold",      bus.dbg_rdata,  32'h1234_5678);
    next_cycle();

    // Continuous contention.
    cpu_drive(1, 0, 9'h005, '0);
    dbg_drive(1, 0, 9'h010, '0);
    for (int k = 0; k < 10; k++) begin
      bit want;
`ifdef DMEM_ARB_RR_EN
      want = (k % 2) == 1;
`else
      want = (k == 4) || (k == 9);
`endif
      @(negedge clk);
      check($sformatf("contend_gnt_%0d", k),   bus.dbg_gnt,   want);
      check($sformatf("contend_stall_%0d", k), bus.cpu_stall, want);
      next_cycle();
    end
    idle();
    next_cycle();

    // Debug read granted, reset in the return cycle.
    dbg_drive(1, 0, 9'h010, '0);
    @(negedge clk);
    check("rst_rd_gnt", bus.dbg_gnt, 1'b1);
    next_cycle();
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("rst_rd_rvalid",    bus.dbg_rvalid, 1'b0);
    check("rst_rd_dbg_rdata", bus.dbg_rdata,  32'h0);
    check("rst_rd_cpu_rdata", bus.cpu_rdata,  32'h0);
    next_cycle();
    @(negedge clk);
    check("rst_rd_rvalid_after", bus.dbg_rvalid, 1'b0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Same-address CPU write versus debug read.
    cpu_drive(0, 1, 9'h020, 32'hCAFE_F00D);
    dbg_drive(1, 0, 9'h020, '0);
    @(negedge clk);
    check("raw_cpu_wr_first", bus.mem_wr,  1'b1);
    check("raw_dbg_wait",     bus.dbg_gnt, 1'b0);
    check("raw_cpu_nostall",  bus.cpu_stall, 1'b0);
    next_cycle();
    cpu_drive(0, 0, '0, '0);
    @(negedge clk);
    check("raw_dbg_gnt", bus.dbg_gnt, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    check("raw_dbg_rvalid", bus.dbg_rvalid, 1'b1);
    check("raw_dbg_rdata",  bus.dbg_rdata,  32'hCAFE_F00D);
    next_cycle();

    // Mixed vectors, checked by the model only.
    mix[0] = '{1, 0, 9'h001, 32'h0,         1, 1, 9'h002, 32'hBEEF_0002};
    mix[1] = '{0, 1, 9'h003, 32'h0BAD_0003, 1, 1, 9'h002, 32'hBEEF_0002};
    mix[2] = '{0, 0, 9'h000, 32'h0,         1, 0, 9'h002, 32'h0};
    mix[3] = '{0, 0, 9'h000, 32'h0,         1, 0, 9'h003, 32'h0};
    mix[4] = '{1, 0, 9'h002, 32'h0,         0, 0, 9'h000, 32'h0};
    mix[5] = '{1, 0, 9'h003, 32'h0,         1, 0, 9'h1FF, 32'h0};
    mix[6] = '{0, 1, 9'h1FF, 32'h7777_8888, 1, 0, 9'h1FF, 32'h0};
    mix[7] = '{0, 0, 9'h000, 32'h0,         1, 0, 9'h1FF, 32'h0};
    foreach (mix[i]) begin
      cpu_drive(mix[i].rd, mix[i].wr, mix[i].ca, mix[i].cd);
      dbg_drive(mix[i].dq, mix[i].dw, mix[i].da, mix[i].dd);
      next_cycle();
    end
    for (int k = 0; k < 12; k++) begin
      cpu_drive(1'($urandom_range(0, 1)), 1'b0, 9'($urandom_range(0, 31)), '0);
      dbg_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                9'($urandom_range(0, 31)), 32'($urandom));
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
